sprite_bouncer: RTL and testbench

Parametrised single-sprite motion engine for the VGA pipeline: holds a rectangular sprite's position and direction, advances it once per frame on a frame tick, bounces it off (or wraps it around) the screen edges, and reports per-pixel coverage and colour to the downstream colour mux. It supersedes per-clock stepping and equality-only edge detection with frame-synchronous updates, edge clamping, a run/pause FSM, bounce reporting and a selectable wrap mode.

---
 rtl/vga_pkg.sv | 17 +
 rtl/axis_step.sv | 83 ++++++++
 rtl/sprite_bouncer.sv | 183 ++++++++++++++++++
 tb/tb_sprite_bouncer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: default resolution, colour widths and the
// sprite motion state type.
package vga_pkg;

    localparam int unsigned H_RES_DEF = 800;
    localparam int unsigned V_RES_DEF = 600;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

endpackage

// File: rtl/axis_step.sv
// One-axis per-frame motion step: computes next position and direction for
// either bounce or wrap behaviour, plus an edge-event flag. Purely combinational.
module axis_step
    import vga_pkg::*;
#(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned SIZE_W  = 9,
    parameter int unsigned DEL_W   = 5
) (
    input  logic [COORD_W-1:0] pos_i,
    input  logic               dir_i,
    input  logic [SIZE_W-1:0]  size_i,
    input  logic [DEL_W-1:0]   del_i,
    input  logic [COORD_W-1:0] res_i,
    input  logic               wrap_mode_i,
    output logic [COORD_W-1:0] next_pos_o,
    output logic               next_dir_o,
    output logic               edge_o
);

    localparam int unsigned SW = COORD_W + 2;

    logic [SW-1:0] pos_w;
    logic [SW-1:0] size_w;
    logic [SW-1:0] del_w;
    logic [SW-1:0] res_w;
    logic [SW-1:0] fwd_w;
    logic [SW-1:0] reach_w;
    logic [SW-1:0] lim_w;

    // Everything is widened so no sum is truncated before it is compared.
    assign pos_w   = SW'(pos_i);
    assign size_w  = SW'(size_i);
    assign del_w   = SW'(del_i);
    assign res_w   = SW'(res_i);
    assign fwd_w   = pos_w + del_w;
    assign reach_w = fwd_w + size_w;
    assign lim_w   = res_w - SW'(1) - size_w;

    always_comb begin
        next_pos_o = pos_i;
        next_dir_o = dir_i;
        edge_o     = 1'b0;
        if (del_w != '0) begin
            if (wrap_mode_i) begin
                if (dir_i) begin
                    if (fwd_w >= res_w) begin
                        next_pos_o = COORD_W'(fwd_w - res_w);
                        edge_o     = 1'b1;
                    end else begin
                        next_pos_o = COORD_W'(fwd_w);
                    end
                end else begin
                    if (pos_w < del_w) begin
                        next_pos_o = COORD_W'(pos_w + res_w - del_w);
                        edge_o     = 1'b1;
                    end else begin
                        next_pos_o = COORD_W'(pos_w - del_w);
                    end
                end
            end else begin
                if (dir_i) begin
                    if (reach_w >= res_w - SW'(1)) begin
                        next_pos_o = COORD_W'(lim_w);
                        next_dir_o = 1'b0;
                        edge_o     = 1'b1;
                    end else begin
                        next_pos_o = COORD_W'(fwd_w);
                    end
                end else begin
                    if (pos_w <= del_w) begin
                        next_pos_o = '0;
                        next_dir_o = 1'b1;
                        edge_o     = 1'b1;
                    end else begin
                        next_pos_o = COORD_W'(pos_w - del_w);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sprite_bouncer.sv
// Single-sprite motion engine: frame-synchronous movement with bounce or wrap,
// run/pause control, edge-event reporting and registered pixel coverage/colour.
module sprite_bouncer
    import vga_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned COORD_W = 11,
    parameter int unsigned SIZE_W  = 9,
    parameter int unsigned DEL_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick_i,
    input  logic               enable_i,
    input  logic               load_i,
    input  logic               wrap_mode_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic [COORD_W-1:0] first_x_i,
    input  logic [COORD_W-1:0] first_y_i,
    input  logic [SIZE_W-1:0]  size_x_i,
    input  logic [SIZE_W-1:0]  size_y_i,
    input  logic [DEL_W-1:0]   del_x_i,
    input  logic [DEL_W-1:0]   del_y_i,
    input  logic [COLOR_W-1:0] color_i,
    output logic               hit_o,
    output logic [CH_W-1:0]    red_o,
    output logic [CH_W-1:0]    green_o,
    output logic [CH_W-1:0]    blue_o,
    output logic               bounce_x_o,
    output logic               bounce_y_o,
    output logic               corner_o,
    output logic [CNT_W-1:0]   bounce_cnt_o,
    output logic [COORD_W-1:0] pos_x_o,
    output logic [COORD_W-1:0] pos_y_o
);

    localparam int unsigned SW = COORD_W + 2;

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic                 bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
    logic                 corner_q, corner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 hit_q, hit_d;
    logic [COLOR_W-1:0]   rgb_q, rgb_d;

    logic [COORD_W-1:0]   start_x, start_y, step_x, step_y;
    logic                 step_dir_x, step_dir_y, edge_x, edge_y;

    // Start position pulled in so the whole sprite fits on screen.
    function automatic logic [COORD_W-1:0] clamp_start(input logic [COORD_W-1:0] first,
                                                       input logic [SIZE_W-1:0]  size,
                                                       input int unsigned        res);
        logic [SW-1:0] lim;
        lim = SW'(res) - SW'(1) - SW'(size);
        return (SW'(first) > lim) ? COORD_W'(lim) : first;
    endfunction

    assign start_x = clamp_start(first_x_i, size_x_i, H_RES);
    assign start_y = clamp_start(first_y_i, size_y_i, V_RES);

    axis_step #(
        .COORD_W(COORD_W),
        .SIZE_W (SIZE_W),
        .DEL_W  (DEL_W)
    ) u_step_x (
        .pos_i      (pos_x_q),
        .dir_i      (dir_x_q),
        .size_i     (size_x_i),
        .del_i      (del_x_i),
        .res_i      (COORD_W'(H_RES)),
        .wrap_mode_i(wrap_mode_i),
        .next_pos_o (step_x),
        .next_dir_o (step_dir_x),
        .edge_o     (edge_x)
    );

    axis_step #(
        .COORD_W(COORD_W),
        .SIZE_W (SIZE_W),
        .DEL_W  (DEL_W)
    ) u_step_y (
        .pos_i      (pos_y_q),
        .dir_i      (dir_y_q),
        .size_i     (size_y_i),
        .del_i      (del_y_i),
        .res_i      (COORD_W'(V_RES)),
        .wrap_mode_i(wrap_mode_i),
        .next_pos_o (step_y),
        .next_dir_o (step_dir_y),
        .edge_o     (edge_y)
    );

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        corner_d   = 1'b0;
        cnt_d      = cnt_q;
        if (load_i) begin
            state_d = StIdle;
            pos_x_d = start_x;
            pos_y_d = start_y;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle:  if (enable_i)  state_d = StRun;
                StRun:   if (!enable_i) state_d = StPause;
                StPause: if (enable_i)  state_d = StRun;
                default: state_d = StIdle;
            endcase
            // The state before the edge decides whether this tick steps.
            if (state_q == StRun && frame_tick_i) begin
                pos_x_d    = step_x;
                pos_y_d    = step_y;
                dir_x_d    = step_dir_x;
                dir_y_d    = step_dir_y;
                bounce_x_d = edge_x;
                bounce_y_d = edge_y;
                corner_d   = edge_x & edge_y;
                if ((edge_x | edge_y) && cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        hit_d = (SW'(pix_x_i) >= SW'(pos_x_q)) &&
                (SW'(pix_x_i) <= SW'(pos_x_q) + SW'(size_x_i)) &&
                (SW'(pix_y_i) >= SW'(pos_y_q)) &&
                (SW'(pix_y_i) <= SW'(pos_y_q) + SW'(size_y_i));
        rgb_d = hit_d ? color_i : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pos_x_q    <= start_x;
            pos_y_q    <= start_y;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            corner_q   <= 1'b0;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
            corner_q   <= corner_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            rgb_q      <= rgb_d;
        end
    end

    assign hit_o        = hit_q;
    assign red_o        = rgb_q[11:8];
    assign green_o      = rgb_q[7:4];
    assign blue_o       = rgb_q[3:0];
    assign bounce_x_o   = bounce_x_q;
    assign bounce_y_o   = bounce_y_q;
    assign corner_o     = corner_q;
    assign bounce_cnt_o = cnt_q;
    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;

endmodule

// File: tb/tb_sprite_bouncer.sv
// Self-checking bench for sprite_bouncer: directed scenarios plus randomized
// stimulus against a behavioural motion model.
module tb_sprite_bouncer;

    localparam int H = 800;
    localparam int V = 600;

    logic        clk = 1'b0;
    logic        reset, frame_tick, enable, load, wrap_mode;
    logic [10:0] pix_x, pix_y, first_x, first_y;
    logic [8:0]  size_x, size_y;
    logic [4:0]  del_x, del_y;
    logic [11:0] color;
    logic        hit, bounce_x, bounce_y, corner;
    logic [3:0]  red, green, blue;
    logic [7:0]  bounce_cnt;
    logic [10:0] pos_x, pos_y;

    always #5 clk = ~clk;

    sprite_bouncer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick_i(frame_tick),
        .enable_i    (enable),
        .load_i      (load),
        .wrap_mode_i (wrap_mode),
        .pix_x_i     (pix_x),
        .pix_y_i     (pix_y),
        .first_x_i   (first_x),
        .first_y_i   (first_y),
        .size_x_i    (size_x),
        .size_y_i    (size_y),
        .del_x_i     (del_x),
        .del_y_i     (del_y),
        .color_i     (color),
        .hit_o       (hit),
        .red_o       (red),
        .green_o     (green),
        .blue_o      (blue),
        .bounce_x_o  (bounce_x),
        .bounce_y_o  (bounce_y),
        .corner_o    (corner),
        .bounce_cnt_o(bounce_cnt),
        .pos_x_o     (pos_x),
        .pos_y_o     (pos_y)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_px, m_py, m_cnt, m_rgb;
    bit m_dx, m_dy, m_bx, m_by, m_hit;
    bit m_run = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int first, input int size, input int res);
        return (first < res - 1 - size) ? first : res - 1 - size;
    endfunction

    function automatic void axis_model(input int pos, input bit dir, input int size,
                                       input int del, input int res, input bit wrap,
                                       output int npos, output bit ndir, output bit edg);
        npos = pos;
        ndir = dir;
        edg  = 1'b0;
        if (del == 0) return;
        if (wrap) begin
            if (dir) begin
                if (pos + del >= res) begin npos = pos + del - res; edg = 1'b1; end
                else npos = pos + del;
            end else begin
                if (pos < del) begin npos = pos + res - del; edg = 1'b1; end
                else npos = pos - del;
            end
        end else begin
            if (dir) begin
                if (pos + size + del >= res - 1) begin
                    npos = res - 1 - size; ndir = 1'b0; edg = 1'b1;
                end else npos = pos + del;
            end else begin
                if (pos <= del) begin npos = 0; ndir = 1'b1; edg = 1'b1; end
                else npos = pos - del;
            end
        end
    endfunction

    task automatic model_edge();
        int nx, ny;
        bit ndx, ndy, ex, ey, hit_now;
        hit_now = (int'(pix_x) >= m_px) && (int'(pix_x) <= m_px + int'(size_x)) &&
                  (int'(pix_y) >= m_py) && (int'(pix_y) <= m_py + int'(size_y));
        m_bx = 1'b0;
        m_by = 1'b0;
        if (reset) begin
            m_hit = 1'b0;
            m_rgb = 0;
            m_px  = clamp(first_x, size_x, H);
            m_py  = clamp(first_y, size_y, V);
            m_dx  = 1'b1;
            m_dy  = 1'b1;
            m_cnt = 0;
        end else begin
            m_hit = hit_now;
            m_rgb = hit_now ? int'(color) : 0;
            if (load) begin
                m_px = clamp(first_x, size_x, H);
                m_py = clamp(first_y, size_y, V);
                m_dx = 1'b1;
                m_dy = 1'b1;
            end else if (m_run && frame_tick) begin
                axis_model(m_px, m_dx, size_x, del_x, H, wrap_mode, nx, ndx, ex);
                axis_model(m_py, m_dy, size_y, del_y, V, wrap_mode, ny, ndy, ey);
                m_px = nx; m_dx = ndx; m_bx = ex;
                m_py = ny; m_dy = ndy; m_by = ey;
                if ((ex || ey) && m_cnt < 255) m_cnt++;
            end
        end
        // Stepping is allowed at the next edge only if enable was seen now.
        m_run = !reset && !load && enable;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("pos_x", pos_x, m_px);
        check_eq("pos_y", pos_y, m_py);
        check_eq("bounce_x", bounce_x, m_bx);
        check_eq("bounce_y", bounce_y, m_by);
        check_eq("corner", corner, m_bx & m_by);
        check_eq("bounce_cnt", bounce_cnt, m_cnt);
        check_eq("hit", hit, m_hit);
        check_eq("rgb", {red, green, blue}, m_rgb);
    endtask

    task automatic tick_after(input int idle_cycles);
        repeat (idle_cycles) cycle();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; load = 1'b0; wrap_mode = 1'b0;
        pix_x = 0; pix_y = 0; first_x = 10; first_y = 20;
        size_x = 49; size_y = 29; del_x = 3; del_y = 2; color = 12'hABC;
        cycle(); cycle();
        check_eq("reset_pos_x", pos_x, 10);
        check_eq("reset_hit", hit, 0);
        reset = 1'b0;

        // Five steps of (3,2) from (10,20)
        for (int t = 0; t < 5; t++) tick_after(3);
        check_eq("plan_pos_x", pos_x, 25);
        check_eq("plan_pos_y", pos_y, 30);
        check_eq("plan_cnt", bounce_cnt, 0);

        // Both axes at their far edge: corner on first tick
        first_x = 750; first_y = 570; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        tick_after(0);
        check_eq("corner_pulse", corner, 1);
        check_eq("corner_pos_x", pos_x, 750);
        check_eq("corner_pos_y", pos_y, 570);
        check_eq("corner_cnt", bounce_cnt, 1);
        tick_after(2);
        check_eq("corner_back_x", pos_x, 747);
        check_eq("corner_back_y", pos_y, 568);

        // Right-edge approach and reversal in bounce mode
        first_x = 745; first_y = 20; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        tick_after(0);
        check_eq("edge_x_748", pos_x, 748);
        tick_after(2);
        check_eq("edge_x_750", pos_x, 750);
        check_eq("edge_bx", bounce_x, 1);
        tick_after(2);
        check_eq("edge_x_747", pos_x, 747);
        tick_after(2);
        check_eq("edge_x_744", pos_x, 744);

        // Wrap mode on the right edge
        wrap_mode = 1'b1; size_x = 0; del_x = 5; first_x = 798; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        tick_after(0);
        check_eq("wrap_x", pos_x, 3);
        check_eq("wrap_bx", bounce_x, 1);
        tick_after(2);
        check_eq("wrap_dir_x", pos_x, 8);

        // Pause freezes position; enable rising on a tick does not step
        enable = 1'b0;
        cycle();
        for (int t = 0; t < 3; t++) tick_after(3);
        check_eq("pause_x", pos_x, 8);
        enable = 1'b1;
        tick_after(0);
        check_eq("resume_tick_x", pos_x, 8);
        tick_after(3);
        check_eq("resume_x", pos_x, 13);

        // load beats a simultaneous tick
        first_x = 200; first_y = 100; load = 1'b1; frame_tick = 1'b1;
        cycle();
        load = 1'b0; frame_tick = 1'b0;
        check_eq("load_tick_x", pos_x, 200);
        tick_after(0);
        check_eq("idle_tick_x", pos_x, 200);

        // Coverage and colour
        wrap_mode = 1'b0; enable = 1'b0; size_x = 9; size_y = 9;
        first_x = 100; first_y = 100; load = 1'b1;
        cycle();
        load = 1'b0; color = 12'h5A3;
        pix_x = 100; pix_y = 100; cycle();
        check_eq("hit_tl", hit, 1);
        check_eq("rgb_tl", {red, green, blue}, 12'h5A3);
        pix_x = 109; pix_y = 109; cycle();
        check_eq("hit_br", hit, 1);
        pix_x = 110; pix_y = 100; cycle();
        check_eq("hit_out", hit, 0);
        check_eq("rgb_out", {red, green, blue}, 0);
        pix_x = 99; pix_y = 105; cycle();
        check_eq("hit_left", hit, 0);

        // Randomized traffic
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 499) == 0);
            load       = ($urandom_range(0, 63) == 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            if (enable) enable = ($urandom_range(0, 31) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 127) == 0) wrap_mode = ~wrap_mode;
            if (reset || load) begin
                first_x = 11'($urandom_range(0, 799));
                first_y = 11'($urandom_range(0, 599));
                size_x  = 9'($urandom_range(0, 511));
                size_y  = 9'($urandom_range(0, 511));
                del_x   = 5'($urandom_range(0, 31));
                del_y   = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 1) == 0) begin
                pix_x = 11'(m_px + int'($urandom_range(0, int'(size_x) + 2)) - 1);
                pix_y = 11'(m_py + int'($urandom_range(0, int'(size_y) + 2)) - 1);
            end else begin
                pix_x = 11'($urandom_range(0, 799));
                pix_y = 11'($urandom_range(0, 599));
            end
            color = 12'($urandom);
            cycle();
        end

        // Frequent bounces until the counter saturates
        reset = 1'b1; load = 1'b0; frame_tick = 1'b0; enable = 1'b1; wrap_mode = 1'b0;
        first_x = 0; first_y = 0; size_x = 511; size_y = 511; del_x = 31; del_y = 31;
        cycle();
        reset = 1'b0;
        for (int t = 0; t < 1200; t++) begin
            pix_x = 11'($urandom_range(0, 799));
            pix_y = 11'($urandom_range(0, 599));
            tick_after(1);
        end
        check_eq("cnt_saturated", bounce_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
